// File: rtl/fifo_pkg.sv
// fifo_pkg -- shared definitions for the parameterised synchronous FIFO.
//
// Contents:
//   DEFAULT_DATA_W / DEFAULT_DEPTH  default geometry for param_sync_fifo
//   clog2()                         constant ceiling-log2 for address widths
//   is_pow2()                       true when a depth is a power of two >= 2
//   thresholds_ok()                 0 <= ae < af <= depth legality check
package fifo_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 16;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit thresholds_ok(input int depth, input int af, input int ae);
    return (ae >= 0) && (ae < af) && (af <= depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem -- DEPTH x DATA_W storage array for param_sync_fifo.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset (clears the read register only)
//   wr_en    write strobe; stores wr_data at wr_addr
//   wr_addr  write address
//   wr_data  write word
//   rd_en    read strobe; loads mem[rd_addr] into rd_data
//   rd_addr  read address
//   rd_data  registered read word, holds when rd_en is low
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately not reset so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/param_sync_fifo.sv
// param_sync_fifo -- single-clock FIFO with programmable thresholds,
// occupancy count, registered read port and sticky error flags.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   wr_en         write request (accepted when not full)
//   wr_data       write word
//   rd_en         read request (accepted when not empty)
//   clr_err       clears overflow/underflow (a same-cycle error wins)
//   rd_data       registered read word, holds when no read is accepted
//   rd_valid      one-cycle pulse per accepted read
//   full / empty  count == DEPTH / count == 0
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   count         occupancy, 0..DEPTH
//   overflow      sticky: write requested while full
//   underflow     sticky: read requested while empty
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  localparam int ADDR_W   = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              clr_err,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  if (DATA_W < 1) begin : g_bad_width
    $error("param_sync_fifo: DATA_W must be at least 1");
  end
  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be a power of two >= 2");
  end
  if (!thresholds_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
    $error("param_sync_fifo: need 0 <= AE_THRESH < AF_THRESH <= DEPTH");
  end

  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0] FULL_C  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_THRESH);

  // One extra pointer bit so wrap-around is modulo 2*DEPTH.
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            wr_accept;
  logic            rd_accept;

  // Flags come only from the registered count: no input-to-flag path.
  assign full         = (count == FULL_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // No pass-through when full and no bypass when empty.
  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + PTR_ONE;
        2'b01:   count <= count - PTR_ONE;
        default: count <= count;
      endcase
      rd_valid <= rd_accept;
      // A new error in the same cycle as clr_err keeps the flag set.
      overflow  <= (wr_en && full)  || (overflow  && !clr_err);
      underflow <= (rd_en && empty) || (underflow && !clr_err);
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (wr_data),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo -- self-checking bench for param_sync_fifo
// (DATA_W=8, DEPTH=16, AF_THRESH=14, AE_THRESH=2). Written words are
// pushed to a scoreboard queue and popped when rd_valid appears.
module tb_param_sync_fifo;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int total;
  int bad;
  int model_count;
  logic [7:0] sb [$];

  param_sync_fifo #(
    .DATA_W    (8),
    .DEPTH     (16),
    .AF_THRESH (14),
    .AE_THRESH (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .clr_err      (clr_err),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle and updates the reference occupancy and scoreboard.
  // Outputs are sampled 1ns after the edge by the caller.
  task automatic drive_cycle(input logic w, input logic [7:0] wd, input logic r,
                             input logic c, output logic exp_rv);
    logic wacc;
    logic racc;
    wacc = w && (model_count != 16);
    racc = r && (model_count != 0);
    if (wacc) sb.push_back(wd);
    model_count = model_count + (wacc ? 1 : 0) - (racc ? 1 : 0);
    exp_rv = racc;
    wr_en = w; wr_data = wd; rd_en = r; clr_err = c;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  task automatic apply_reset(input int cycles, input logic w, input logic r);
    rst = 1'b1; wr_en = w; rd_en = r; wr_data = 8'h77; clr_err = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    model_count = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    apply_reset(2, 1'b1, 1'b1);
    total++; if (count !== 5'd0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty got=%b want=1", empty); end
    total++; if (almost_empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_aempty got=%b want=1", almost_empty); end
    total++; if (full !== 1'b0 || almost_full !== 1'b0) begin bad++; $display("[TB] FAIL reset_full got=%b%b want=00", full, almost_full); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rd_valid got=%b want=0", rd_valid); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_rd_data got=%h want=00", rd_data); end
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b%b want=00", overflow, underflow); end
  endtask

  task automatic test_fill_drain();
    logic rv;
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b1, 8'(i), 1'b0, 1'b0, rv);
      total++; if (count !== 5'(model_count)) begin bad++; $display("[TB] FAIL fill_count got=%0d want=%0d", count, model_count); end
      total++; if (almost_full !== (model_count >= 14)) begin bad++; $display("[TB] FAIL fill_afull cnt=%0d got=%b", model_count, almost_full); end
      total++; if (full !== (model_count == 16)) begin bad++; $display("[TB] FAIL fill_full cnt=%0d got=%b", model_count, full); end
      total++; if (almost_empty !== (model_count <= 2) || empty !== 1'b0) begin bad++; $display("[TB] FAIL fill_empty cnt=%0d got=%b%b", model_count, almost_empty, empty); end
    end
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, rv);
      total++; if (rd_valid !== rv) begin bad++; $display("[TB] FAIL drain_valid got=%b want=%b", rd_valid, rv); end
      if (rv) begin
        exp = sb.pop_front();
        total++; if (rd_data !== exp) begin bad++; $display("[TB] FAIL drain_data got=%h want=%h", rd_data, exp); end
      end
      total++; if (count !== 5'(model_count)) begin bad++; $display("[TB] FAIL drain_count got=%0d want=%0d", count, model_count); end
      total++; if (almost_empty !== (model_count <= 2) || empty !== (model_count == 0)) begin bad++; $display("[TB] FAIL drain_empty cnt=%0d got=%b%b", model_count, almost_empty, empty); end
      total++; if (almost_full !== (model_count >= 14) || full !== 1'b0) begin bad++; $display("[TB] FAIL drain_full cnt=%0d got=%b%b", model_count, almost_full, full); end
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, rv);
    total++; if (rd_valid !== 1'b0 || rd_data !== 8'h0F) begin bad++; $display("[TB] FAIL hold_rd got=%b/%h want=0/0f", rd_valid, rd_data); end
  endtask

  task automatic test_overflow();
    logic rv;
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) drive_cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, rv);
    drive_cycle(1'b1, 8'hAA, 1'b0, 1'b0, rv);
    total++; if (count !== 5'd16 || full !== 1'b1) begin bad++; $display("[TB] FAIL ovf_count got=%0d/%b want=16/1", count, full); end
    total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag got=%b want=1", overflow); end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, rv);
    total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_sticky got=%b want=1", overflow); end
    drive_cycle(1'b1, 8'hAA, 1'b0, 1'b1, rv);
    total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_clr_wins got=%b want=1", overflow); end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, rv);
    total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL ovf_clr got=%b want=0", overflow); end
    // Full with read and write together: read proceeds, write rejected.
    drive_cycle(1'b1, 8'hAA, 1'b1, 1'b0, rv);
    total++; if (count !== 5'd15 || overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_rw got=%0d/%b want=15/1", count, overflow); end
    if (rv) begin
      exp = sb.pop_front();
      total++; if (rd_data !== exp) begin bad++; $display("[TB] FAIL ovf_rw_data got=%h want=%h", rd_data, exp); end
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, rv);
    for (int i = 0; i < 15; i++) begin
      drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, rv);
      total++; if (rd_valid !== rv) begin bad++; $display("[TB] FAIL ovf_drain_valid got=%b want=%b", rd_valid, rv); end
      if (rv) begin
        exp = sb.pop_front();
        total++; if (rd_data !== exp) begin bad++; $display("[TB] FAIL ovf_drain_data got=%h want=%h", rd_data, exp); end
      end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("[TB] FAIL ovf_end_empty got=%b want=1", empty); end
  endtask

  task automatic test_underflow();
    logic rv;
    logic [7:0] exp;
    drive_cycle(1'b1, 8'h55, 1'b1, 1'b0, rv);
    total++; if (underflow !== 1'b1) begin bad++; $display("[TB] FAIL udf_flag got=%b want=1", underflow); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL udf_valid got=%b want=0", rd_valid); end
    total++; if (count !== 5'd1 || empty !== 1'b0) begin bad++; $display("[TB] FAIL udf_count got=%0d want=1", count); end
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, rv);
    total++; if (rd_valid !== rv) begin bad++; $display("[TB] FAIL udf_read_valid got=%b want=%b", rd_valid, rv); end
    if (rv) begin
      exp = sb.pop_front();
      total++; if (rd_data !== exp) begin bad++; $display("[TB] FAIL udf_read_data got=%h want=%h", rd_data, exp); end
    end
    drive_cycle(1'b0, 8'h00, 1'b0, 1'b1, rv);
    total++; if (underflow !== 1'b0) begin bad++; $display("[TB] FAIL udf_clr got=%b want=0", underflow); end
  endtask

  task automatic test_wrap();
    logic rv;
    logic [7:0] exp;
    logic [7:0] d;
    d = 8'h10;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, d, 1'b0, 1'b0, rv);
      d = d + 8'd1;
    end
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1'b1, d, 1'b1, 1'b0, rv);
      d = d + 8'd1;
      total++; if (count !== 5'd8) begin bad++; $display("[TB] FAIL wrap_count got=%0d want=8", count); end
      total++; if (rd_valid !== rv) begin bad++; $display("[TB] FAIL wrap_valid got=%b want=%b", rd_valid, rv); end
      if (rv) begin
        exp = sb.pop_front();
        total++; if (rd_data !== exp) begin bad++; $display("[TB] FAIL wrap_data got=%h want=%h", rd_data, exp); end
      end
    end
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, rv);
      if (rv) begin
        exp = sb.pop_front();
        total++; if (rd_data !== exp) begin bad++; $display("[TB] FAIL wrap_tail got=%h want=%h", rd_data, exp); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic rv;
    logic [7:0] exp;
    for (int i = 0; i < 9; i++) drive_cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, rv);
    total++; if (count !== 5'd9) begin bad++; $display("[TB] FAIL mid_pre_count got=%0d want=9", count); end
    apply_reset(1, 1'b0, 1'b0);
    total++; if (count !== 5'd0 || empty !== 1'b1) begin bad++; $display("[TB] FAIL mid_reset got=%0d/%b want=0/1", count, empty); end
    drive_cycle(1'b1, 8'h3C, 1'b0, 1'b0, rv);
    drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, rv);
    total++; if (rd_valid !== rv) begin bad++; $display("[TB] FAIL mid_valid got=%b want=%b", rd_valid, rv); end
    if (rv) begin
      exp = sb.pop_front();
      total++; if (rd_data !== exp) begin bad++; $display("[TB] FAIL mid_data got=%h want=%h", rd_data, exp); end
    end
    total++; if (rd_data !== 8'h3C) begin bad++; $display("[TB] FAIL mid_const got=%h want=3c", rd_data); end
  endtask

  initial begin
    total = 0; bad = 0; model_count = 0;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00; clr_err = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
